// File: rtl/conv_sequencer.sv
// Control sequencer for the binary 2-D convolution engine: owns memory addressing,
// row/column counting and output write timing for runtime kernel sizes 1..KMAX.
module conv_sequencer #(
  parameter int unsigned       KMAX     = 5,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 12,
  parameter logic [DATA_W-1:0] END_MARK = 16'h00FF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic              dut_sram_write_enable,
  output logic [2:0]        kdim,
  output logic              ld_weight_row,
  output logic [2:0]        wrow_idx,
  output logic              shift_row,
  output logic              update_d_in,
  output logic [3:0]        col_idx,
  output logic              err_kdim
);

  localparam logic [3:0] StIdle  = 4'd0;
  localparam logic [3:0] StWk    = 4'd1;
  localparam logic [3:0] StWrows = 4'd2;
  localparam logic [3:0] StHdr   = 4'd3;
  localparam logic [3:0] StPrime = 4'd4;
  localparam logic [3:0] StSweep = 4'd5;
  localparam logic [3:0] StWrite = 4'd6;
  localparam logic [3:0] StAdv   = 4'd7;
  localparam logic [3:0] StDone  = 4'd8;

  localparam logic [DATA_W-1:0] KMaxW  = DATA_W'(KMAX);
  localparam logic [DATA_W-1:0] MaxCol = DATA_W'(DATA_W);

  logic [3:0]        state_q, state_d;
  logic [1:0]        ph_q, ph_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wm_addr_q, wm_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [2:0]        kdim_q, kdim_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] nrows_q, nrows_d;
  logic [DATA_W-1:0] ncols_q, ncols_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W:0]   out_q, out_d;

  logic [DATA_W-1:0] k_ext;
  logic              more_rows;

  assign k_ext = DATA_W'(kdim_q);
  // Another output row is due while outputs produced + K <= nrows.
  assign more_rows = (out_q + (DATA_W + 1)'(kdim_q)) <= {1'b0, nrows_q};

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    rd_addr_d = rd_addr_q;
    wm_addr_d = wm_addr_q;
    wr_addr_d = wr_addr_q;
    kdim_d    = kdim_q;
    err_d     = err_q;
    nrows_d   = nrows_q;
    ncols_d   = ncols_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    case (state_q)
      StIdle: begin
        if (dut_run) begin
          state_d   = StWk;
          ph_d      = 2'd0;
          wm_addr_d = '0;
          wr_addr_d = '0;
          err_d     = 1'b0;
        end
      end
      StWk: begin
        if (ph_q == 2'd0) begin
          ph_d = 2'd1;
        end else if (wmem_dut_read_data == '0 || wmem_dut_read_data > KMaxW) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          kdim_d    = wmem_dut_read_data[2:0];
          wm_addr_d = ADDR_W'(1);
          cnt_d     = '0;
          state_d   = StWrows;
        end
      end
      StWrows: begin
        if (cnt_q == k_ext) begin
          state_d = StHdr;
          ph_d    = 2'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 < k_ext) wm_addr_d = wm_addr_q + 1'b1;
        end
      end
      StHdr: begin
        // Phases: nrows addr, nrows data, ncols addr, ncols data.
        case (ph_q)
          2'd0: ph_d = 2'd1;
          2'd1: begin
            nrows_d = sram_dut_read_data;
            if (sram_dut_read_data == END_MARK) begin
              state_d = StDone;
            end else begin
              rd_addr_d = rd_addr_q + 1'b1;
              ph_d      = 2'd2;
            end
          end
          2'd2: ph_d = 2'd3;
          default: begin
            ncols_d = sram_dut_read_data;
            if (k_ext > nrows_q || k_ext > sram_dut_read_data || sram_dut_read_data > MaxCol) begin
              rd_addr_d = rd_addr_q + 1'b1 + ADDR_W'(nrows_q);
              ph_d      = 2'd0;
            end else begin
              rd_addr_d = rd_addr_q + 1'b1;
              cnt_d     = '0;
              out_d     = '0;
              state_d   = StPrime;
            end
          end
        endcase
      end
      StPrime: begin
        if (cnt_q == k_ext) begin
          cnt_d   = '0;
          state_d = StSweep;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      StSweep: begin
        if (cnt_q == ncols_q - k_ext) begin
          cnt_d   = '0;
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrite: begin
        wr_addr_d = wr_addr_q + 1'b1;
        out_d     = out_q + 1'b1;
        ph_d      = 2'd0;
        state_d   = StAdv;
      end
      StAdv: begin
        if (ph_q == 2'd0) begin
          if (more_rows) begin
            rd_addr_d = rd_addr_q + 1'b1;
            ph_d      = 2'd1;
          end else begin
            state_d = StHdr;
          end
        end else begin
          cnt_d   = '0;
          state_d = StSweep;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= StIdle;
      ph_q      <= 2'd0;
      rd_addr_q <= '0;
      wm_addr_q <= '0;
      wr_addr_q <= '0;
      kdim_q    <= '0;
      err_q     <= 1'b0;
      nrows_q   <= '0;
      ncols_q   <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      rd_addr_q <= rd_addr_d;
      wm_addr_q <= wm_addr_d;
      wr_addr_q <= wr_addr_d;
      kdim_q    <= kdim_d;
      err_q     <= err_d;
      nrows_q   <= nrows_d;
      ncols_q   <= ncols_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
    end
  end

  // Strobes decode from state so an asynchronous reset silences them at once.
  always_comb begin
    dut_busy               = (state_q != StIdle) && (state_q != StDone);
    dut_sram_read_address  = rd_addr_q;
    dut_wmem_read_address  = wm_addr_q;
    dut_sram_write_address = wr_addr_q;
    dut_sram_write_enable  = (state_q == StWrite);
    kdim                   = kdim_q;
    err_kdim               = err_q;
    ld_weight_row          = (state_q == StWrows) && (cnt_q != '0);
    wrow_idx               = ld_weight_row ? 3'(cnt_q - 1'b1) : 3'd0;
    shift_row              = ((state_q == StPrime) && (cnt_q != '0)) ||
                             ((state_q == StAdv) && (ph_q == 2'd1));
    update_d_in            = (state_q == StSweep);
    col_idx                = update_d_in ? cnt_q[3:0] : 4'd0;
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: memories are modelled here; expected event streams for each job
// are derived from the memory contents by a behavioural model of the image-walking rules.
module tb_conv_sequencer;

  localparam int          KMAX     = 5;
  localparam int          DATA_W   = 16;
  localparam int          ADDR_W   = 12;
  localparam logic [15:0] END_MARK = 16'h00FF;

  logic              clk = 1'b0;
  logic              reset_b = 1'b0;
  logic              dut_run = 1'b0;
  logic              dut_busy;
  logic [ADDR_W-1:0] dut_sram_read_address;
  logic [DATA_W-1:0] sram_dut_read_data;
  logic [ADDR_W-1:0] dut_wmem_read_address;
  logic [DATA_W-1:0] wmem_dut_read_data;
  logic [ADDR_W-1:0] dut_sram_write_address;
  logic              dut_sram_write_enable;
  logic [2:0]        kdim;
  logic              ld_weight_row;
  logic [2:0]        wrow_idx;
  logic              shift_row;
  logic              update_d_in;
  logic [3:0]        col_idx;
  logic              err_kdim;

  conv_sequencer #(
    .KMAX    (KMAX),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .END_MARK(END_MARK)
  ) dut (
    .clk                   (clk),
    .reset_b               (reset_b),
    .dut_run               (dut_run),
    .dut_busy              (dut_busy),
    .dut_sram_read_address (dut_sram_read_address),
    .sram_dut_read_data    (sram_dut_read_data),
    .dut_wmem_read_address (dut_wmem_read_address),
    .wmem_dut_read_data    (wmem_dut_read_data),
    .dut_sram_write_address(dut_sram_write_address),
    .dut_sram_write_enable (dut_sram_write_enable),
    .kdim                  (kdim),
    .ld_weight_row         (ld_weight_row),
    .wrow_idx              (wrow_idx),
    .shift_row             (shift_row),
    .update_d_in           (update_d_in),
    .col_idx               (col_idx),
    .err_kdim              (err_kdim)
  );

  always #5 clk = ~clk;

  logic [15:0] sram_mem [0:4095];
  logic [15:0] wmem_mem [0:4095];

  always @(posedge clk) begin
    sram_dut_read_data <= sram_mem[dut_sram_read_address];
    wmem_dut_read_data <= wmem_mem[dut_wmem_read_address];
  end

  int checks = 0;
  int errors = 0;

  int wr_log[$], sw_log[$], row_log[$], wl_log[$];
  int run_len, col_bad, wl_bad, busy_cyc, prev_rd, prev_wm;
  int exp_sw[$], exp_rows[$];
  int exp_writes, exp_end;
  bit exp_err;
  int wp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_log.delete(); sw_log.delete(); row_log.delete(); wl_log.delete();
    run_len = 0; col_bad = 0; wl_bad = 0; busy_cyc = 0;
    prev_rd = int'(dut_sram_read_address);
    prev_wm = int'(dut_wmem_read_address);
  endtask

  // Called once per cycle at the falling edge.
  task automatic sample();
    if (dut_sram_write_enable) wr_log.push_back(int'(dut_sram_write_address));
    if (update_d_in) begin
      if (int'(col_idx) != run_len) col_bad++;
      run_len++;
    end else if (run_len != 0) begin
      sw_log.push_back(run_len);
      run_len = 0;
    end
    if (shift_row) row_log.push_back(prev_rd);
    if (ld_weight_row) begin
      wl_log.push_back(int'(wrow_idx));
      if (prev_wm != int'(wrow_idx) + 1) wl_bad++;
    end
    if (dut_busy) busy_cyc++;
    prev_rd = int'(dut_sram_read_address);
    prev_wm = int'(dut_wmem_read_address);
  endtask

  task automatic fill_w(input int k);
    wmem_mem[0] = 16'(k);
    for (int i = 1; i <= k; i++) wmem_mem[i] = 16'($urandom);
  endtask

  task automatic put_image(input int nr, input int nc);
    sram_mem[wp]     = 16'(nr);
    sram_mem[wp + 1] = 16'(nc);
    for (int r = 0; r < nr; r++) sram_mem[wp + 2 + r] = 16'($urandom);
    wp += 2 + nr;
  endtask

  task automatic put_end();
    sram_mem[wp] = END_MARK;
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
  endtask

  // Walk the image list from address 0 as the job is defined to.
  task automatic build_expected(input int k);
    int a;
    exp_sw.delete();
    exp_rows.delete();
    exp_writes = 0;
    exp_end    = 0;
    exp_err    = (k == 0) || (k > KMAX);
    a = 0;
    if (!exp_err) begin
      for (int g = 0; g < 64; g++) begin
        int nr, nc;
        nr = int'(sram_mem[a]);
        if (sram_mem[a] == END_MARK) break;
        nc = int'(sram_mem[a + 1]);
        if (!(k > nr || k > nc || nc > DATA_W)) begin
          for (int r = 0; r < nr; r++) exp_rows.push_back(a + 2 + r);
          for (int o = 0; o < nr - k + 1; o++) exp_sw.push_back(nc - k + 1);
          exp_writes += nr - k + 1;
        end
        a += 2 + nr;
      end
    end
    exp_end = a;
  endtask

  task automatic run_job(input int k, input bit poke);
    int n;
    bit ok;
    build_expected(k);
    clear_logs();
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    sample();
    check("busy_rise", dut_busy, 1);
    check("err_cleared_on_run", err_kdim, 0);
    n = 0;
    while (dut_busy && n < 4000) begin
      @(negedge clk);
      dut_run = (poke && n == 8 && dut_busy);
      sample();
      n++;
    end
    dut_run = 1'b0;
    check("busy_timeout", n < 4000, 1);
    check("err_kdim", err_kdim, exp_err);
    if (!exp_err) check("kdim", kdim, k);
    check("n_writes", wr_log.size(), exp_writes);
    ok = 1;
    foreach (wr_log[i]) if (wr_log[i] != i) ok = 0;
    check("wr_addr_seq", ok, 1);
    check("n_sweeps", sw_log.size(), exp_sw.size());
    ok = 1;
    foreach (sw_log[i]) if (i >= exp_sw.size() || sw_log[i] != exp_sw[i]) ok = 0;
    check("sweep_len", ok, 1);
    check("col_idx_seq", col_bad, 0);
    check("n_shift_row", row_log.size(), exp_rows.size());
    ok = 1;
    foreach (row_log[i]) if (i >= exp_rows.size() || row_log[i] != exp_rows[i]) ok = 0;
    check("shift_row_addr", ok, 1);
    check("n_wload", wl_log.size(), exp_err ? 0 : k);
    ok = 1;
    foreach (wl_log[i]) if (wl_log[i] != i) ok = 0;
    check("wrow_idx_seq", ok, 1);
    check("wmem_addr", wl_bad, 0);
    check("end_rd_addr", dut_sram_read_address, exp_end);
    if (exp_err) check("err_busy_len", busy_cyc <= 3, 1);
  endtask

  initial begin
    int n;
    reset_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state",
          {dut_busy, dut_sram_read_address, dut_wmem_read_address, dut_sram_write_address,
           dut_sram_write_enable, kdim, ld_weight_row, wrow_idx, shift_row, update_d_in,
           col_idx, err_kdim}, 0);
    reset_b = 1'b1;
    @(negedge clk);

    // K=3, 4x5 image
    fill_w(3); wp = 0; put_image(4, 5); put_end();
    run_job(3, 1'b0);

    // K=1, 2x2 image
    do_reset();
    fill_w(1); wp = 0; put_image(2, 2); put_end();
    run_job(1, 1'b0);

    // K=KMAX, 5x16 image, with a dut_run poke while busy
    do_reset();
    fill_w(5); wp = 0; put_image(5, 16); put_end();
    run_job(5, 1'b1);

    // Illegal K, then a legal job clears the sticky error
    do_reset();
    fill_w(6); wp = 0; put_image(4, 5); put_end();
    run_job(6, 1'b0);
    fill_w(3);
    run_job(3, 1'b0);

    // Three images with the middle one skipped
    do_reset();
    fill_w(3); wp = 0; put_image(3, 3); put_image(2, 8); put_image(4, 4); put_end();
    run_job(3, 1'b0);
    if (row_log.size() > 3) check("third_image_first_row", row_log[3], 11);

    // Reset in the middle of a sweep
    do_reset();
    fill_w(2); wp = 0; put_image(4, 8); put_end();
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    n = 0;
    while (!update_d_in && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("sweep_reached", update_d_in, 1);
    reset_b = 1'b0;
    #1;
    check("rst_busy", dut_busy, 0);
    check("rst_we", dut_sram_write_enable, 0);
    check("rst_strobes", {update_d_in, shift_row, ld_weight_row}, 0);
    check("rst_addrs", {dut_sram_read_address, dut_sram_write_address}, 0);
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    run_job(2, 1'b0);

    // Randomized jobs
    for (int j = 0; j < 6; j++) begin
      int k, nimg;
      do_reset();
      k = int'($urandom_range(1, KMAX));
      fill_w(k);
      wp = 0;
      nimg = int'($urandom_range(1, 3));
      for (int m = 0; m < nimg; m++)
        put_image(int'($urandom_range(0, 6)), int'($urandom_range(1, 17)));
      put_end();
      run_job(k, (j % 2) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Parametrised control sequencer for the binary 2-D convolution engine; successor to the fixed 3x3 controller FSM.
- Owns all SRAM/WMEM addressing, row/column counters and output write timing internally, instead of taking flags from the datapath.
- Supports runtime kernel size 1..KMAX and back-to-back images until the end marker.
- Drives the existing shift-row/d_in datapath through strobes.

Parameters:
- KMAX, 5: largest supported kernel dimension K.
- DATA_W, 16: SRAM/WMEM word width; also the maximum image columns.
- ADDR_W, 12: address width of the input, weight and output memories.
- END_MARK, 16'h00FF: an nrows word equal to this value ends the job.

Ports:
- clk  in  1  single clock (already decided).
- reset_b  in  1  asynchronous active-low reset (already decided).
- dut_run  in  1  start pulse; sampled in IDLE only.
- dut_busy  out  1  high from the cycle after dut_run is accepted until the job ends.
- dut_sram_read_address  out  ADDR_W  input image read address.
- sram_dut_read_data  in  DATA_W  read data, valid 1 cycle after the address.
- dut_wmem_read_address  out  ADDR_W  weight memory address.
- wmem_dut_read_data  in  DATA_W  weight data, valid 1 cycle after the address.
- dut_sram_write_address  out  ADDR_W  output address.
- dut_sram_write_enable  out  1  1-cycle write strobe per output row.
- kdim  out  3  latched kernel size K.
- ld_weight_row  out  1  datapath captures wmem data as weight row wrow_idx.
- wrow_idx  out  3  weight row index, 0..K-1.
- shift_row  out  1  datapath shifts sram data into the K-row window.
- update_d_in  out  1  datapath evaluates the window at col_idx.
- col_idx  out  4  current output column, 0..ncols-K.
- err_kdim  out  1  sticky; set on an illegal K; cleared by the next accepted dut_run.

Behaviour:
- Reset:
  - State IDLE.
  - All addresses 0, all strobes 0, dut_busy 0, kdim 0, counters 0, err_kdim 0.
- Memory layout:
  - Input SRAM per image: nrows, ncols, then nrows row words (bit j = pixel j).
  - WMEM: word 0 = K; words 1..K = weight rows.
  - Output: one word per output row, written sequentially from address 0. Images are packed back to back.
- States:
  - IDLE: on dut_run, go to WK; reset the weight and write addresses; dut_busy rises next cycle.
  - WK: read WMEM word 0.
    - K = 0 or K > KMAX: set err_kdim and go to DONE.
    - Otherwise latch kdim and go to WROWS.
  - WROWS: issue wmem addresses 1..K. Each following cycle pulses ld_weight_row with wrow_idx = 0..K-1. Total K+1 cycles, then HDR.
  - HDR: read nrows. If nrows == END_MARK, go to DONE; the ncols read is skipped. Otherwise read ncols.
    - K > nrows or K > ncols or ncols > DATA_W: advance the read address past nrows rows with no writes, then HDR again.
    - Otherwise go to PRIME.
  - PRIME: K consecutive row reads; each returning word pulses shift_row.
  - SWEEP: update_d_in asserted for ncols-K+1 consecutive cycles, col_idx 0..ncols-K.
  - WRITE: 1 cycle after the last column, dut_sram_write_enable = 1. The write address increments the following cycle.
  - ADV:
    - If outputs produced < nrows-K+1: one row read plus shift_row, then SWEEP.
    - Else the next image's address is already in place; go to HDR.
  - DONE: dut_busy falls; return to IDLE in 1 cycle.
- Weights are loaded once per job and reused for every image.
- The read address only increments; it never wraps in-job. Overflow past 2^ADDR_W-1 wraps modulo and is not flagged.
- dut_run while busy is ignored.
- reset_b low mid-job returns every output to its reset value immediately. No partial write strobe may be emitted.
- Counter arithmetic is unsigned at DIM_W=DATA_W. Comparisons use the full word, so nrows=0x0100 is legal-size-checked, not END_MARK.

Test Plan:
- K=3; image 4x5; then END_MARK:
  - 2 writes, at output addresses 0 and 1.
  - Each SWEEP has 3 update_d_in cycles with col_idx 0,1,2.
  - dut_busy falls after the END_MARK read.
- K=1, 2x2 image:
  - 2 rows written.
  - PRIME has 1 shift_row.
  - SWEEP is 2 cycles.
- K=5=KMAX, 5x16 image: exactly 1 write; 12 update_d_in cycles.
- K=6 (> KMAX):
  - err_kdim = 1, no input reads, no writes, dut_busy low within 3 cycles.
  - The next dut_run with K=3 clears err_kdim.
- Three images: 3x3, 2x8 (skipped, K > nrows), 4x4:
  - Writes at addresses 0, 1, 2.
  - The third image header is read at address 2+3+2+2 = 9.
- Reset asserted during SWEEP:
  - Same cycle: dut_busy = 0 and write_enable = 0.
  - After release, a new dut_run restarts from address 0.
